// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : multi-cycle FSM control unit for an RV32I-subset datapath
// Rev 1.0
// ============================================================================
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic [3:0]       status,
    output logic             pcsrc,
    output logic             alusrc,
    output logic [3:0]       aluop,
    output logic             mrw,
    output logic             wb,
    output logic             regrw,
    output logic [1:0]       immgen_ctrl,
    output logic             pc_we,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] c_opc_r  = 7'b0110011;
    localparam logic [6:0] c_opc_i  = 7'b0010011;
    localparam logic [6:0] c_opc_ld = 7'b0000011;
    localparam logic [6:0] c_opc_st = 7'b0100011;
    localparam logic [6:0] c_opc_br = 7'b1100011;

    localparam logic [3:0] c_alu_add  = 4'b0000;
    localparam logic [3:0] c_alu_sub  = 4'b0001;
    localparam logic [3:0] c_alu_and  = 4'b0010;
    localparam logic [3:0] c_alu_or   = 4'b0011;
    localparam logic [3:0] c_alu_xor  = 4'b0100;
    localparam logic [3:0] c_alu_sll  = 4'b0101;
    localparam logic [3:0] c_alu_srl  = 4'b0110;
    localparam logic [3:0] c_alu_sra  = 4'b0111;
    localparam logic [3:0] c_alu_slt  = 4'b1000;
    localparam logic [3:0] c_alu_sltu = 4'b1001;

    state_t           r_state;
    logic [31:0]      r_ir;
    logic             r_trap;
    logic [CNT_W-1:0] r_retired;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br;
    logic       w_legal;
    logic       w_alt;
    logic [3:0] w_aluop;
    logic       w_br_taken;
    logic       w_unused;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_is_r   = (w_opcode == c_opc_r);
    assign w_is_i   = (w_opcode == c_opc_i);
    assign w_is_ld  = (w_opcode == c_opc_ld);
    assign w_is_st  = (w_opcode == c_opc_st);
    assign w_is_br  = (w_opcode == c_opc_br);

    assign w_legal = w_is_r | w_is_i
                   | ((w_is_ld | w_is_st) & (w_funct3 == 3'b010))
                   | (w_is_br & ((w_funct3 == 3'b000) | (w_funct3 == 3'b001) |
                                 (w_funct3 == 3'b100) | (w_funct3 == 3'b101)));

    // funct7[5] selects SUB only for R-type; shifts honour it for both R and I.
    assign w_alt = r_ir[30] & (w_is_r | (w_funct3 == 3'b101));

    always_comb begin
        w_aluop = c_alu_add;
        if (w_is_br) begin
            w_aluop = c_alu_sub;
        end else if (w_is_r | w_is_i) begin
            case (w_funct3)
                3'b000:  w_aluop = w_alt ? c_alu_sub : c_alu_add;
                3'b001:  w_aluop = c_alu_sll;
                3'b010:  w_aluop = c_alu_slt;
                3'b011:  w_aluop = c_alu_sltu;
                3'b100:  w_aluop = c_alu_xor;
                3'b101:  w_aluop = w_alt ? c_alu_sra : c_alu_srl;
                3'b110:  w_aluop = c_alu_or;
                default: w_aluop = c_alu_and;
            endcase
        end
    end

    always_comb begin
        case (w_funct3)
            3'b000:  w_br_taken = status[0];
            3'b001:  w_br_taken = ~status[0];
            3'b100:  w_br_taken = status[1] ^ status[3];
            default: w_br_taken = ~(status[1] ^ status[3]);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_trap    <= 1'b0;
            r_retired <= '0;
        end else begin
            if (pc_we) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            case (r_state)
                S_FETCH: begin
                    r_ir    <= instr;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_is_r | w_is_i)       r_state <= S_WB;
                    else if (w_is_ld | w_is_st) r_state <= S_MEM;
                    else                        r_state <= S_FETCH;
                end
                S_MEM:   r_state <= w_is_ld ? S_WB : S_FETCH;
                S_WB:    r_state <= S_FETCH;
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Datapath selects are held from EXEC to the final state so alu_out stays stable.
    always_comb begin
        alusrc      = 1'b0;
        aluop       = 4'b0000;
        immgen_ctrl = 2'b00;
        wb          = 1'b0;
        if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) begin
            alusrc      = ~(w_is_r | w_is_br);
            aluop       = w_aluop;
            immgen_ctrl = w_is_st ? 2'b01 : (w_is_br ? 2'b10 : 2'b00);
            wb          = w_is_r | w_is_i;
        end
    end

    assign pc_we   = (r_state == S_WB)
                   | ((r_state == S_MEM)  & w_is_st)
                   | ((r_state == S_EXEC) & w_is_br);
    assign regrw   = (r_state == S_WB);
    assign mrw     = (r_state == S_MEM) & w_is_st;
    assign pcsrc   = (r_state == S_EXEC) & w_is_br & w_br_taken;
    assign trap    = r_trap;
    assign retired = r_retired;

    assign w_unused = ^{r_ir[31], r_ir[29:15], r_ir[11:7], status[2]};

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_multicycle_ctrl : scoreboard bench for the multi-cycle control unit
// Rev 1.0
// ============================================================================
module tb_multicycle_ctrl;

    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [31:0]         instr;
    logic [3:0]          status;
    logic                pcsrc, alusrc, mrw, wb, regrw, pc_we, trap;
    logic [3:0]          aluop;
    logic [1:0]          immgen_ctrl;
    logic [TB_CNT_W-1:0] retired;

    int tests = 0;
    int fails = 0;

    // ctl packing: {pcsrc, alusrc, aluop[3:0], mrw, wb, regrw, immgen[1:0]}
    typedef struct packed {
        logic [10:0]         ctl;
        logic [TB_CNT_W-1:0] ret;
    } sb_t;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  status;
        logic [10:0] ctl;
        int          lat;
    } vec_t;

    sb_t                 sbq[$];
    logic [TB_CNT_W-1:0] model_ret = '0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .status      (status),
        .pcsrc       (pcsrc),
        .alusrc      (alusrc),
        .aluop       (aluop),
        .mrw         (mrw),
        .wb          (wb),
        .regrw       (regrw),
        .immgen_ctrl (immgen_ctrl),
        .pc_we       (pc_we),
        .trap        (trap),
        .retired     (retired)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({pcsrc, alusrc, aluop, mrw, wb, regrw, immgen_ctrl, pc_we, trap, retired});
    endfunction

    // Monitor: every pc_we pulse must match the oldest expected completion.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && pc_we === 1'b1) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pc_we: got pc_we=1 expected no completion");
                end else begin
                    e = sbq.pop_front();
                    check("completion_ctl",
                          32'({pcsrc, alusrc, aluop, mrw, wb, regrw, immgen_ctrl}), 32'(e.ctl));
                    check("completion_retired", 32'(retired), 32'(e.ret));
                end
            end
        end
    end

    // Called at a negedge with the DUT in FETCH; returns at the next FETCH negedge.
    task automatic run_instr(input vec_t v);
        sb_t e;
        int  lat;
        instr  = v.instr;
        status = v.status;
        e.ctl  = v.ctl;
        e.ret  = model_ret;
        sbq.push_back(e);
        model_ret = model_ret + 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k >= 3)
                check("body_selects", 32'({alusrc, aluop, wb, immgen_ctrl}),
                      32'({v.ctl[9:5], v.ctl[3], v.ctl[1:0]}));
            if (pc_we === 1'b1) begin
                lat = k;
                break;
            end
            check("strobes_idle", 32'({regrw, mrw, pcsrc}), 32'd0);
            @(negedge clk);
        end
        check("latency", 32'(lat), 32'(v.lat));
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        check("outputs_in_reset", all_outs(), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_ret = '0;
    endtask

    vec_t vecs[13] = '{
        '{32'h002081B3, 4'b0000, {1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b00}, 4}, // add
        '{32'h402081B3, 4'b0000, {1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 2'b00}, 4}, // sub
        '{32'h4020D1B3, 4'b0000, {1'b0, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b1, 2'b00}, 4}, // sra
        '{32'h0020E1B3, 4'b0000, {1'b0, 1'b0, 4'b0011, 1'b0, 1'b1, 1'b1, 2'b00}, 4}, // or
        '{32'h00508093, 4'b0000, {1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b00}, 4}, // addi
        '{32'h40008093, 4'b0000, {1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b00}, 4}, // addi, bit30 ignored
        '{32'h4010D093, 4'b0000, {1'b0, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b1, 2'b00}, 4}, // srai
        '{32'h0040A183, 4'b0000, {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b00}, 5}, // lw
        '{32'h0030A223, 4'b0000, {1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b01}, 4}, // sw
        '{32'h00208463, 4'b0001, {1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'b10}, 3}, // beq Z=1
        '{32'h00208463, 4'b0000, {1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'b10}, 3}, // beq Z=0
        '{32'h0020C463, 4'b0010, {1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'b10}, 3}, // blt N=1 V=0
        '{32'h0020D463, 4'b1010, {1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'b10}, 3}  // bge N=1 V=1
    };

    logic [31:0] illegal[3] = '{32'h0000007F, 32'h00002063, 32'h00000003};

    initial begin
        vec_t add_v;
        reset  = 1'b0;
        instr  = 32'h0;
        status = 4'h0;
        repeat (2) @(negedge clk);
        check("reset_state", all_outs(), 32'd0);
        reset = 1'b1;

        // Abort an ADD in EXEC; the monitor flags any completion that follows.
        instr = 32'h002081B3;
        @(negedge clk);
        @(negedge clk);
        pulse_reset();
        check("retired_after_abort", 32'(retired), 32'd0);

        foreach (vecs[i]) run_instr(vecs[i]);

        foreach (illegal[i]) begin
            instr = illegal[i];
            @(negedge clk);
            check("trap_before_decode_edge", 32'(trap), 32'd0);
            @(negedge clk);
            check("trap_set", 32'(trap), 32'd1);
            repeat (5) begin
                @(negedge clk);
                check("trap_frozen", 32'({trap, pc_we, regrw, mrw, pcsrc, retired}),
                      32'({1'b1, 4'b0000, model_ret}));
            end
            pulse_reset();
            check("trap_cleared", 32'(trap), 32'd0);
        end

        add_v = vecs[0];
        for (int n = 0; n < 17; n++) run_instr(add_v);
        check("retired_wrapped", 32'(retired), 32'd1);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
